avst_channel_adapter: RTL and testbench
=======================================

AVST_CHANNEL_ADAPTER -- requirements
Module: avst_channel_adapter

Interface
REQ-001 Parameter DATA_W, default 8: width of the data payload in bits.
REQ-002 Parameter IN_CHANNEL_W, default 8: width of the input channel field.
REQ-003 Parameter OUT_CHANNEL_W, default 1: width of the output channel field; must be <= IN_CHANNEL_W.
REQ-004 Parameter MAX_CHANNEL, default 0: highest channel number forwarded downstream.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_ready  output  1  sink accepts a beat.
REQ-008 in_valid  input  1  source beat valid.
REQ-009 in_data  input  DATA_W  beat payload.
REQ-010 in_channel  input  IN_CHANNEL_W  channel of the beat.
REQ-011 in_startofpacket, in_endofpacket  input  1 each  packet delimiters.
REQ-012 out_ready  input  1  downstream accepts a beat.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_data  output  DATA_W  payload.
REQ-015 out_channel  output  OUT_CHANNEL_W  low OUT_CHANNEL_W bits of the packet's channel.
REQ-016 out_startofpacket, out_endofpacket  output  1 each  delimiters.
REQ-017 drop_count  output  16  number of packets dropped, saturating.

Function
REQ-018 A beat is transferred on either side only on a cycle where valid and ready are both high.
REQ-019 The output stage shall be a 2-entry skid buffer: in_ready is a register equal to "skid entry empty", giving full throughput and no combinational path from out_ready to in_ready.
REQ-020 Latency from accepted input beat to out_valid shall be exactly 1 cycle when the buffer is empty.
REQ-021 Packet FSM states are IDLE, PASS and DROP; reset state is IDLE.
REQ-022 IDLE: an accepted beat (SOP asserted or not) latches in_channel; if the channel <= MAX_CHANNEL the beat is forwarded and the FSM goes to PASS, otherwise the beat is discarded and the FSM goes to DROP.
REQ-023 A beat with both SOP and EOP shall be handled as a whole packet, and the FSM shall stay in or return to IDLE.
REQ-024 PASS: beats are forwarded with the latched channel, and mid-packet in_channel is ignored; an accepted EOP returns the FSM to IDLE.
REQ-025 DROP: in_ready follows the skid-buffer rule, accepted beats are discarded, and an accepted EOP returns the FSM to IDLE.
REQ-026 An accepted SOP in PASS or DROP (missing EOP) shall be treated as the start of a new packet and evaluated as in IDLE.
REQ-027 drop_count shall increment by 1 on each packet entering the dropped path, and shall saturate at 16'hFFFF.
REQ-028 The block shall never fill a forwarded beat into the buffer when the buffer is full; dropped beats never occupy buffer entries.
REQ-029 Output payload, channel and delimiters shall be held stable while out_valid is high and out_ready is low.

Reset
REQ-030 Reset values: out_valid=0, in_ready=0 during reset and 1 on the first cycle after reset, FSM=IDLE, drop_count=0, buffer entries empty; data outputs are don't-care but driven 0.
REQ-031 Reset asserted mid-packet shall discard all buffered beats, and the next accepted beat is evaluated as in IDLE.

Configuration
REQ-032 Macro AVST_CHAN_ADAPT_STATS_EN: when defined, the drop counter is implemented per REQ-027; when undefined, no counter register exists, drop_count is tied to 0, and all other behaviour is unchanged.

Structure
REQ-033 A shared package avst_adapt_pkg shall hold the FSM state enum (IDLE, PASS, DROP) and the DROP_CNT_W=16 constant.
REQ-034 The skid buffer shall be a separate sub-module avst_skid_buffer, parametrised by payload width, instantiated once.

Verification
REQ-035 MAX_CHANNEL=0: a 4-beat packet on channel 0 with out_ready=1 -> 4 beats out, each 1 cycle later, with SOP/EOP preserved and out_channel=0.
REQ-036 A 3-beat packet on channel 5 -> no out_valid, in_ready stays 1, drop_count 0->1.
REQ-037 Channel 0 packet with out_ready held low for 3 cycles at beat 2 -> in_ready falls after the buffer fills, no beat is lost or duplicated, and data order is preserved.
REQ-038 Packet whose channel changes from 0 to 7 at beat 2 -> all beats forwarded with out_channel=0.
REQ-039 Packet on channel 3 without EOP, followed by SOP on channel 0 -> the second packet is forwarded and drop_count=1.
REQ-040 drop_count preset near its limit (force to 16'hFFFE), then 3 bad packets -> reads 16'hFFFF; repeat without AVST_CHAN_ADAPT_STATS_EN -> drop_count stays 0.

Source files
------------

// File: rtl/avst_adapt_pkg.sv
// Shared types and constants for the Avalon-ST channel adapter.
package avst_adapt_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/avst_skid_buffer.sv
// Two-entry skid buffer: registered output slot plus one skid slot.
// in_ready_o is a register meaning "skid slot empty"; no path from out_ready_i to in_ready_o.
module avst_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         push_c;

    assign push_c = in_valid_i & in_ready_q;

    // Output slot refills from the skid slot first; a push into a stalled output lands in the skid slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push_c;
                if (push_c) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (push_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/avst_channel_adapter.sv
// Avalon-ST channel adapter: forwards packets on channels <= MAX_CHANNEL, drops the rest.
// Define AVST_CHAN_ADAPT_STATS_EN to build the saturating drop_count register; otherwise it reads 0.
module avst_channel_adapter
    import avst_adapt_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned IN_CHANNEL_W  = 8,
    parameter int unsigned OUT_CHANNEL_W = 1,
    parameter int unsigned MAX_CHANNEL   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int unsigned PAYLOAD_W = DATA_W + OUT_CHANNEL_W + 2;

    pkt_state_e               state_q, state_d;
    logic [OUT_CHANNEL_W-1:0] chan_q, chan_c;
    logic                     accept_c, start_c, chan_ok_c, fwd_c;
    logic [PAYLOAD_W-1:0]     skid_in_c, skid_out_c;

    assign accept_c = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An SOP always restarts packet evaluation, even if the previous packet never saw its EOP.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            if (in_endofpacket) begin
                state_d = IDLE;
            end else if (start_c) begin
                state_d = chan_ok_c ? PASS : DROP;
            end
        end
    end

    always_comb begin
        start_c   = (state_q == IDLE) || in_startofpacket;
        chan_ok_c = 32'(in_channel) <= MAX_CHANNEL;
        fwd_c     = start_c ? chan_ok_c : (state_q == PASS);
        chan_c    = start_c ? in_channel[OUT_CHANNEL_W-1:0] : chan_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q <= '0;
        end else if (accept_c && start_c) begin
            chan_q <= in_channel[OUT_CHANNEL_W-1:0];
        end
    end

    assign skid_in_c = {in_data, chan_c, in_startofpacket, in_endofpacket};

    avst_skid_buffer #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid & fwd_c),
        .in_ready_o  (in_ready),
        .in_data_i   (skid_in_c),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (skid_out_c)
    );

    assign {out_data, out_channel, out_startofpacket, out_endofpacket} = skid_out_c;

`ifdef AVST_CHAN_ADAPT_STATS_EN
    logic                  drop_pkt_c;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign drop_pkt_c = accept_c & start_c & ~chan_ok_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_pkt_c && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_avst_channel_adapter.sv
// Randomised and directed bench for avst_channel_adapter against a packet-level reference model.
module tb_avst_channel_adapter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned OUT_W  = 1;
    localparam int unsigned MAX_CH = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OUT_W-1:0]  ch;
        logic              sop;
        logic              eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_ready;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [IN_W-1:0]   in_channel = '0;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [OUT_W-1:0]  out_channel;
    logic              out_sop;
    logic              out_eop;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    avst_channel_adapter #(
        .DATA_W        (DATA_W),
        .IN_CHANNEL_W  (IN_W),
        .OUT_CHANNEL_W (OUT_W),
        .MAX_CHANNEL   (MAX_CH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_channel        (in_channel),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .drop_count        (drop_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Reference model: a packet's fate is decided by its first beat (or any SOP).
    beat_t       exp_q[$];
    bit          m_in_pkt = 1'b0;
    bit          m_fwd    = 1'b0;
    logic [IN_W-1:0] m_ch = '0;
    int unsigned m_drops  = 0;

    task automatic model_beat(input logic [DATA_W-1:0] d, input logic [IN_W-1:0] ch,
                              input logic sop, input logic eop);
        beat_t b;
        if (!m_in_pkt || sop) begin
            m_fwd = (ch <= MAX_CH);
            m_ch  = ch;
            if (!m_fwd) m_drops++;
        end
        if (m_fwd) begin
            b.data = d;
            b.ch   = m_ch[OUT_W-1:0];
            b.sop  = sop;
            b.eop  = eop;
            exp_q.push_back(b);
        end
        m_in_pkt = !eop;
    endtask

    function automatic logic [31:0] exp_drop();
`ifdef AVST_CHAN_ADAPT_STATS_EN
        return (m_drops > 32'hFFFF) ? 32'hFFFF : m_drops;
`else
        return 32'h0;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [IN_W-1:0] ch,
                             input logic sop, input logic eop, input int gap);
        bit ok = 1'b0;
        int n  = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        model_beat(d, ch, sop, eop);
        in_valid   = 1'b1;
        in_data    = d;
        in_channel = ch;
        in_sop     = sop;
        in_eop     = eop;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: ordering, content and hold-while-stalled.
    bit    stall_q = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = {out_data, out_channel, out_sop, out_eop};
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_payload", 32'(cur), 32'(held));
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_channel", 32'(out_channel), 32'(e.ch));
                    chk("out_sop", 32'(out_sop), 32'(e.sop));
                    chk("out_eop", 32'(out_eop), 32'(e.eop));
                end
            end
            stall_q = out_valid && !out_ready;
            held    = cur;
        end
    end

    bit rnd_done = 1'b0;

    initial begin
        logic [DATA_W-1:0] d;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 4-beat channel-0 packet, one-cycle latency per beat
        chk("lat_idle_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h10 + i);
            send_beat(d, 8'd0, i == 0, i == 3, 0);
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("lat_data", 32'(out_data), 32'(d));
        end
        drain();

        // 3-beat packet on channel 5 is dropped
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(8'h50 + i), 8'd5, i == 0, i == 2, 0);
            chk("drop_in_ready", 32'(in_ready), 32'd1);
            chk("drop_no_valid", 32'(out_valid), 32'd0);
        end
        chk("drop_count_1", 32'(drop_count), exp_drop());

        // Backpressure for 3 cycles from beat 2
        send_beat(8'hA0, 8'd0, 1'b1, 1'b0, 0);
        fork
            begin
                send_beat(8'hA1, 8'd0, 1'b0, 1'b0, 0);
                send_beat(8'hA2, 8'd0, 1'b0, 1'b0, 0);
                send_beat(8'hA3, 8'd0, 1'b0, 1'b1, 0);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Mid-packet channel change is ignored
        for (int i = 0; i < 4; i++)
            send_beat(8'(8'hC0 + i), (i >= 2) ? 8'd7 : 8'd0, i == 0, i == 3, 0);
        drain();

        // Channel-3 packet missing EOP, then a fresh SOP on channel 0
        send_beat(8'hD0, 8'd3, 1'b1, 1'b0, 0);
        send_beat(8'hD1, 8'd3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++)
            send_beat(8'(8'hE0 + i), 8'd0, i == 0, i == 2, 0);
        drain();
        chk("drop_count_2", 32'(drop_count), exp_drop());

        // Randomised traffic with random backpressure
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
            begin
                for (int p = 0; p < 60; p++) begin
                    int unsigned len;
                    logic [IN_W-1:0] ch, bch;
                    bit no_eop, no_sop;
                    len    = $urandom_range(1, 5);
                    ch     = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    no_eop = ($urandom_range(0, 7) == 0);
                    no_sop = ($urandom_range(0, 9) == 0);
                    for (int i = 0; i < int'(len); i++) begin
                        bch = (i > 0 && $urandom_range(0, 3) == 0) ? 8'($urandom) : ch;
                        send_beat(8'($urandom), bch, (i == 0) && !no_sop,
                                  (i == int'(len) - 1) && !no_eop, $urandom_range(0, 2));
                    end
                end
                rnd_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("drop_count_rnd", 32'(drop_count), exp_drop());

        // Reset in the middle of a packet with a full buffer
        out_ready = 1'b0;
        send_beat(8'hF0, 8'd0, 1'b1, 1'b0, 0);
        send_beat(8'hF1, 8'd0, 1'b0, 1'b0, 0);
        reset = 1'b1;
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_drops  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_back", 32'(in_ready), 32'd1);
        chk("mid_rst_empty", 32'(out_valid), 32'd0);
        send_beat(8'h71, 8'd0, 1'b0, 1'b0, 0);
        send_beat(8'h72, 8'd0, 1'b0, 1'b1, 0);
        send_beat(8'h73, 8'd6, 1'b0, 1'b1, 0);
        drain();
        chk("mid_rst_drop_after", 32'(drop_count), exp_drop());

        // Drop counter saturation
`ifdef AVST_CHAN_ADAPT_STATS_EN
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        m_drops = 32'hFFFE;
        @(posedge clk);
        #1;
`endif
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(8'h90 + i), 8'd9, 1'b1, 1'b1, 0);
            chk("sat_drop_count", 32'(drop_count), exp_drop());
        end

        drain();
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
